// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Holds the default width/depth and the configuration legality check used at elaboration.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // True when STAGES evenly splits WIDTH and 1 <= STAGES <= WIDTH.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    if (stages < 1) return 1'b0;
    if (stages > width) return 1'b0;
    return (width % stages) == 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered SW-bit slice of the pipelined adder.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          advance enable; the slice holds its result when low
//   a_sl, b_sl  operand slices (b_sl already inverted for subtract)
//   ci          carry into the slice LSB
//   s_sl        registered slice sum
//   co          registered carry out of the slice MSB
//   c_msb_in    registered carry into the slice MSB (feeds signed overflow)
module adder_slice #(
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SW-1:0] a_sl,
  input  logic [SW-1:0] b_sl,
  input  logic          ci,
  output logic [SW-1:0] s_sl,
  output logic          co,
  output logic          c_msb_in
);

  logic [SW:0] total;
  logic        msb_carry;

  assign total = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, ci};

  // The top sum bit is a^b^carry_in, so the carry into the MSB falls out by XOR.
  assign msb_carry = total[SW-1] ^ a_sl[SW-1] ^ b_sl[SW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_sl     <= '0;
      co       <= 1'b0;
      c_msb_in <= 1'b0;
    end else if (en) begin
      s_sl     <= total[SW-1:0];
      co       <= total[SW];
      c_msb_in <= msb_carry;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two-operand add/subtract unit with valid/ready handshake on both sides.
// The WIDTH-bit add is split into STAGES registered slices; the carry ripples one slice per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake (in_ready is combinational from pipeline state)
//   a, b, cin, sub        operands; sub=1 computes a-b as a+~b+1 and ignores cin
//   out_valid, out_ready  output handshake
//   sum, cout, ovf        registered result, carry out of MSB, signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
  end

  logic adv;

  // Per-stage word: finished result slices below the active slice, operand A above it.
  logic [WIDTH-1:0]  word_in  [STAGES];
  logic [WIDTH-1:0]  word_out [STAGES];
  logic [WIDTH-1:0]  bp_in    [STAGES];
  logic [WIDTH-1:0]  bp_q     [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_out;
  logic [STAGES-1:0] c_msb;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] v_q;

  // The whole pipe moves together; a full pipe stalls every stage, bubbles are not squeezed.
  assign adv      = out_ready | ~v_q[STAGES-1];
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned      LO         = k * SW;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << LO;

    logic [WIDTH-1:0] pass_q;
    logic [WIDTH-1:0] bp_r;
    logic             valid_r;
    logic [SW-1:0]    s_sl;

    if (k == 0) begin : g_first
      assign word_in[k] = a;
      assign bp_in[k]   = sub ? ~b : b;
      assign c_in[k]    = sub | cin;
      assign v_in[k]    = in_valid;
    end else begin : g_next
      assign word_in[k] = word_out[k-1];
      assign bp_in[k]   = bp_q[k-1];
      assign c_in[k]    = c_out[k-1];
      assign v_in[k]    = v_q[k-1];
    end

    adder_slice #(
      .SW(SW)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .a_sl     (word_in[k][LO +: SW]),
      .b_sl     (bp_in[k][LO +: SW]),
      .ci       (c_in[k]),
      .s_sl     (s_sl),
      .co       (c_out[k]),
      .c_msb_in (c_msb[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        pass_q  <= '0;
        bp_r    <= '0;
      end else if (adv) begin
        valid_r <= v_in[k];
        pass_q  <= word_in[k];
        bp_r    <= bp_in[k];
      end
    end

    assign v_q[k]      = valid_r;
    assign bp_q[k]     = bp_r;
    assign word_out[k] = (pass_q & ~SLICE_MASK) | (WIDTH'(s_sl) << LO);
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = word_out[STAGES-1];
  assign cout      = c_out[STAGES-1];
  assign ovf       = c_out[STAGES-1] ^ c_msb[STAGES-1];

  // Last-stage B' and the inner MSB carries have no consumer.
  logic unused_tail;
  assign unused_tail = ^{bp_q[STAGES-1], c_msb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder.
// Drives a 16-bit/4-stage unit plus 1-stage and 16-stage builds fed with the same accepted operands;
// each build has its own scoreboard queue of expected results and latencies.
module tb_pipelined_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy4, ov4, co4, of4;
  logic [15:0] s4;
  logic        rdy1, ov1, co1, of1;
  logic [15:0] s1;
  logic        rdy16, ov16, co16, of16;
  logic [15:0] s16;
  logic        iv_side;

  exp_t cur_exp;
  exp_t e4, e1, e16;
  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];
  bit   lat_en = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops4 = 0;
  int   first_pop4 = 0;
  int   last_pop4 = 0;

  // Side builds only take what the main unit takes, so all three see identical streams.
  assign iv_side = in_valid & rdy4;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4), .ovf(of4)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_side), .in_ready(rdy1), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov1), .out_ready(1'b1), .sum(s1), .cout(co1), .ovf(of1)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_side), .in_ready(rdy16), .a(a), .b(b), .cin(cin),
    .sub(sub), .out_valid(ov16), .out_ready(1'b1), .sum(s16), .cout(co16), .ovf(of16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {ovf, cout, sum} from a plain full-width add.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] yb;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    yb   = s ? ~y : y;
    c0   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yb} + {16'd0, c0};
    low  = {1'b0, x[14:0]} + {1'b0, yb[14:0]} + {15'd0, c0};
    return {full[16] ^ low[15], full[16], full[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic score(input string nm, input logic [15:0] s, input logic co, input logic ov,
                       input exp_t e, input int lat);
    check({nm, " sum"}, {16'd0, s}, {16'd0, e.sum});
    check({nm, " cout"}, {31'd0, co}, {31'd0, e.cout});
    check({nm, " ovf"}, {31'd0, ov}, {31'd0, e.ovf});
    if (e.lat) check({nm, " latency"}, cyc - e.acc_cyc, lat);
  endtask

  task automatic unexpected(input string nm, input logic [15:0] s);
    checks++;
    errors++;
    $display("FAIL %s unexpected output: got sum %0h expected no output", nm, s);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && rdy4) begin
        e4 = cur_exp; e4.acc_cyc = cyc; e4.lat = lat_en; q4.push_back(e4);
      end
      if (ov4 && out_ready) begin
        if (q4.size() == 0) unexpected("dut4", s4);
        else begin
          e4 = q4.pop_front();
          score("dut4", s4, co4, of4, e4, 4);
          if (pops4 == 0) first_pop4 = cyc;
          last_pop4 = cyc;
          pops4++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (iv_side && rdy1) begin
        e1 = cur_exp; e1.acc_cyc = cyc; e1.lat = lat_en; q1.push_back(e1);
      end
      if (ov1) begin
        if (q1.size() == 0) unexpected("dut1", s1);
        else begin
          e1 = q1.pop_front();
          score("dut1", s1, co1, of1, e1, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (iv_side && rdy16) begin
        e16 = cur_exp; e16.acc_cyc = cyc; e16.lat = lat_en; q16.push_back(e16);
      end
      if (ov16) begin
        if (q16.size() == 0) unexpected("dut16", s16);
        else begin
          e16 = q16.pop_front();
          score("dut16", s16, co16, of16, e16, 16);
        end
      end
    end
  end

  // Present one operand set and return at the negedge where it is accepted.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic ts, input logic [17:0] want);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    cur_exp.sum = want[15:0]; cur_exp.cout = want[16]; cur_exp.ovf = want[17];
    cur_exp.acc_cyc = 0; cur_exp.lat = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rdy4 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!rdy4) begin
      checks++; errors++;
      $display("FAIL send timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic send_rand();
    logic [15:0] ra, rb;
    logic rc, rs;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    logic [17:0] first_exp;
    logic [17:0] m;
    int          n;
    int          ov_after;

    tbl[0] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[1] = '{16'd32,   16'd16,   1'b0, 1'b0, 16'd48,   1'b0, 1'b0};
    tbl[2] = '{16'd256,  16'd0,    1'b1, 1'b0, 16'd257,  1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'd5,    16'd7,    1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[6] = '{16'd7,    16'd5,    1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[8] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, ov4}, 0);
    check("reset sum", {16'd0, s4}, 0);
    check("reset cout", {31'd0, co4}, 0);
    check("reset ovf", {31'd0, of4}, 0);
    check("reset in_ready", {31'd0, rdy4}, 1);
    check("reset out_valid s1/s16", {30'd0, ov1, ov16}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
      idle();
      repeat (3) @(posedge clk);
    end
    repeat (20) @(posedge clk);

    // Back-to-back stream of 8.
    pops4 = 0;
    for (int i = 0; i < 8; i++) send_rand();
    idle();
    repeat (20) @(posedge clk);
    check("stream count", pops4, 8);
    check("stream consecutive", last_pop4 - first_pop4, 7);

    // Backpressure with the pipe full.
    lat_en = 1'b0;
    first_exp = model(16'h1111, 16'h0F0F, 1'b1, 1'b0);
    send(16'h1111, 16'h0F0F, 1'b1, 1'b0, first_exp);
    for (int i = 0; i < 3; i++) send_rand();
    @(posedge clk); #1;
    out_ready = 1'b0;
    a = 16'h4000; b = 16'h0123; cin = 1'b0; sub = 1'b1;
    m = model(16'h4000, 16'h0123, 1'b0, 1'b1);
    cur_exp.sum = m[15:0]; cur_exp.cout = m[16]; cur_exp.ovf = m[17];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready", {31'd0, rdy4}, 0);
      check("stall out_valid", {31'd0, ov4}, 1);
      check("stall sum held", {16'd0, s4}, {16'd0, first_exp[15:0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", {31'd0, rdy4}, 1);
    for (int i = 0; i < 3; i++) send_rand();
    idle();
    repeat (25) @(posedge clk);
    check("drain q4", q4.size(), 0);

    // Reset with results in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    idle();
    n = 0;
    @(negedge clk);
    while (!ov4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("pipe holds result before reset", {31'd0, ov4}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", {31'd0, ov4}, 0);
    check("async reset sum", {16'd0, s4}, 0);
    check("async reset in_ready", {31'd0, rdy4}, 1);
    check("async reset side out_valid", {30'd0, ov1, ov16}, 0);
    q4.delete(); q1.delete(); q16.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    ov_after = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov4 || ov1 || ov16) ov_after++;
    end
    check("no stale after reset", ov_after, 0);
    lat_en = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, model(16'h00FF, 16'h0001, 1'b0, 1'b0));
    idle();
    repeat (25) @(posedge clk);

    check("final q4 empty", q4.size(), 0);
    check("final q1 empty", q1.size(), 0);
    check("final q16 empty", q16.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
